// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack port plus the IF/ID presentation bus of the fetch sequencer.
interface fetch_ctrl_if #(
  parameter int unsigned W = 32
);
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         if_valid;
  logic [W-1:0] if_pc;
  logic [W-1:0] if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_inst,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_inst,
    output imem_ack, imem_rdata
  );
endinterface

// File: rtl/fetch_ctrl.sv
// MIPS32 instruction-fetch sequencer: PC ownership, redirect arbitration, skid on stall.
// Optional FETCH_CTRL_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_ctrl #(
  parameter int unsigned W        = 32,
  parameter logic [W-1:0] RESET_PC = '0,
  parameter logic [W-1:0] EXC_VEC  = W'(32'h0000_0180)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         branch_take,
  input  logic [W-1:0] targ_pc,
  input  logic         exc_take,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_squashed
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);
  localparam logic [W-1:0] PC_STEP    = W'(4);

  state_t       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         req_q, req_d;
  logic         pend_q, pend_d;
  logic         pend_exc_q, pend_exc_d;
  logic [W-1:0] rpc_q, rpc_d;
  logic [W-1:0] skid_pc_q, skid_pc_d;
  logic [W-1:0] skid_inst_q, skid_inst_d;
  logic         if_valid_q, if_valid_d;
  logic [W-1:0] if_pc_q, if_pc_d;
  logic [W-1:0] if_inst_q, if_inst_d;
  logic         deliver_c, squash_c;

  logic         redir_c;
  logic [W-1:0] exc_tgt_c, br_tgt_c, redir_tgt_c;

  assign redir_c     = exc_take | branch_take;
  assign exc_tgt_c   = EXC_VEC & ALIGN_MASK;
  assign br_tgt_c    = targ_pc & ALIGN_MASK;
  assign redir_tgt_c = exc_take ? exc_tgt_c : br_tgt_c;

  // Next-state, PC selection and IF/ID presentation.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    pend_d      = pend_q;
    pend_exc_d  = pend_exc_q;
    rpc_d       = rpc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_valid_d  = stall ? if_valid_q : 1'b0;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    deliver_c   = 1'b0;
    squash_c    = 1'b0;

    // A redirect always flushes the wrong-path instruction.
    if (redir_c) if_valid_d = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        req_d   = 1'b1;
        if (redir_c) pc_d = redir_tgt_c;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          if (pend_q || redir_c) begin
            squash_c   = 1'b1;
            pend_d     = 1'b0;
            pend_exc_d = 1'b0;
            if (exc_take)                       pc_d = exc_tgt_c;
            else if (branch_take && !pend_exc_q) pc_d = br_tgt_c;
            else                                pc_d = rpc_q;
          end else if (!stall || !if_valid_q) begin
            deliver_c  = 1'b1;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = bus.imem_rdata;
            pc_d       = pc_q + PC_STEP;
          end else begin
            skid_pc_d   = pc_q;
            skid_inst_d = bus.imem_rdata;
            pc_d        = pc_q + PC_STEP;
            state_d     = HOLD;
            req_d       = 1'b0;
          end
        end else if (exc_take) begin
          pend_d     = 1'b1;
          pend_exc_d = 1'b1;
          rpc_d      = exc_tgt_c;
        end else if (branch_take && !pend_exc_q) begin
          pend_d = 1'b1;
          rpc_d  = br_tgt_c;
        end
      end
      HOLD: begin
        if (redir_c) begin
          squash_c = 1'b1;
          pc_d     = redir_tgt_c;
          state_d  = FETCH;
          req_d    = 1'b1;
        end else if (!stall) begin
          deliver_c  = 1'b1;
          if_valid_d = 1'b1;
          if_pc_d    = skid_pc_q;
          if_inst_d  = skid_inst_q;
          state_d    = FETCH;
          req_d      = 1'b1;
        end
      end
      default: begin
        state_d = BOOT;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_exc_q  <= 1'b0;
      rpc_q       <= '0;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      pend_exc_q  <= pend_exc_d;
      rpc_q       <= rpc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_squashed_q, perf_squashed_d;

  // Delivered words and squashed words (discarded acks or dropped skid entries).
  always_comb begin
    perf_fetched_d  = perf_fetched_q + 32'(deliver_c);
    perf_squashed_d = perf_squashed_q + 32'(squash_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      perf_fetched_q  <= perf_fetched_d;
      perf_squashed_q <= perf_squashed_d;
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`else
  logic unused_perf_c;
  assign unused_perf_c = deliver_c ^ squash_c;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS32 pipeline.
- Owns the architectural fetch PC and chooses each cycle between sequential PC+4, a branch/jump target and the exception vector.
- Drives a request/acknowledge instruction-memory port and presents fetched words to the IF/ID stage, honouring pipeline stall.
- Sits between the branch-resolution logic, the exception unit and the instruction memory.

Parameters:
W, 32, word and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
EXC_VEC, 32'h0000_0180, exception redirect target

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
stall  input  1  IF/ID cannot accept; hold presented instruction
branch_take  input  1  one-cycle redirect request to targ_pc
targ_pc  input  W  branch/jump target, sampled when branch_take=1
exc_take  input  1  one-cycle redirect request to EXC_VEC
imem_req  output  1  memory request valid
imem_addr  output  W  request address, word aligned
imem_ack  input  1  request accepted and data valid this cycle
imem_rdata  input  W  instruction word, valid with imem_ack
if_valid  output  1  if_inst/if_pc hold a live instruction
if_pc  output  W  PC of presented instruction
if_inst  output  W  presented instruction

Behaviour:
- Reset (rst=0 at an edge): state=BOOT, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, pend=0. Reset mid-request abandons it; any later stray imem_ack is ignored in BOOT.
- States:
  - BOOT: after one cycle, go to FETCH with imem_req=1, imem_addr=pc.
  - FETCH: imem_req=1 with imem_addr held stable until imem_ack.
  - HOLD: word captured but stall=1; imem_req=0.
- Memory protocol: imem_ack is legal in any cycle with imem_req=1, including the first. Exactly one ack per request. Latency is unbounded.
- Redirect priority: exc_take > branch_take > sequential. The redirect address is word-aligned by clearing bits [1:0].
- Redirect while no ack is pending: set pend=1 and rpc=target. An exc_take in a later cycle overwrites a pending branch. A branch never overwrites a pending exception.
- Redirect in the same cycle as imem_ack: the acked word is discarded.
- FETCH with imem_ack:
  - If pend, or a redirect arrives this cycle: discard the word (if_valid unchanged/0), next imem_addr = redirect target, clear pend, stay in FETCH.
  - Else, if stall=0 or if_valid=0: load if_inst=imem_rdata, if_pc=imem_addr, if_valid=1; pc=imem_addr+4; issue next request next cycle.
  - Else (stall=1 and if_valid=1): load the word into a one-entry skid register and go to HOLD.
- HOLD:
  - On stall=0: move the skid word to the if_* outputs and return to FETCH with pc+4.
  - A redirect in HOLD drops the skid word, sets if_valid=0 and fetches the target.
- if_valid with stall=1: if_* held unchanged.
- if_valid with stall=0 and no new word: if_valid drops to 0 next cycle.
- Any redirect clears if_valid next cycle (flush of the wrong-path instruction).
- PC arithmetic is modulo 2^W: 32'hFFFF_FFFC + 4 = 0, no trap.
- Throughput: with single-cycle ack and no stall, one instruction per cycle back-to-back (imem_req stays high).

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN
- Defined: adds output ports perf_fetched (32-bit) and perf_squashed (32-bit).
  - perf_fetched increments on each ack whose word is delivered.
  - perf_squashed increments on each ack discarded or skid word dropped by a redirect.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, imem_ack tied 1, stall=0 -> imem_addr sequence 0,4,8,C on consecutive cycles; if_pc follows one cycle later; if_valid=1 from the third cycle.
- branch_take=1, targ_pc=32'h0000_0400 while ack is delayed 3 cycles -> the in-flight word is discarded; next imem_addr=400; if_valid=0 until the 400 word arrives; perf_squashed=1 if enabled.
- branch_take (target 400) then exc_take two cycles later, both before the ack -> next fetch address is 180. Reversed order -> still 180.
- stall=1 for 4 cycles with ack tied 1 -> if_pc/if_inst held; one word kept in skid; imem_req=0. On stall release, the skid word is presented next cycle and fetch resumes at skid_pc+4.
- RESET_PC=32'hFFFF_FFFC -> second fetch address is 0.
- rst=0 asserted while imem_req=1 and unacked, with an ack on the reset cycle -> all outputs equal reset values; first post-reset fetch is RESET_PC; no if_valid from the stale ack.
